// File: rtl/spi_frame_tx_if.sv
// ---------------------------------------------------------------------------
// spi_frame_tx_if
//
// Groups the request handshake and the SPI pins of spi_frame_tx.
//
// Signals:
//   start  request to send a frame (accepted when start && ready)
//   frame  payload, frame[FRAME_BITS-1] is transmitted first
//   ready  transmitter idle and able to accept start
//   busy   frame in flight (cycle after accept until done)
//   done   one-cycle pulse on the first cs-high cycle after a frame
//   sck    serial clock, idle low
//   cs     chip select, active-low, idle high
//   sdo    serial data out, MSB first
//
// Modports:
//   master  the transmitter itself (SPI master, answers start)
//   slave   the client side that requests frames and observes the link
// ---------------------------------------------------------------------------
interface spi_frame_tx_if #(
  parameter int FRAME_BITS = 336
);
  logic                  start;
  logic [FRAME_BITS-1:0] frame;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  sck;
  logic                  cs;
  logic                  sdo;

  modport master (
    input  start,
    input  frame,
    output ready,
    output busy,
    output done,
    output sck,
    output cs,
    output sdo
  );

  modport slave (
    output start,
    output frame,
    input  ready,
    input  busy,
    input  done,
    input  sck,
    input  cs,
    input  sdo
  );
endinterface

// File: rtl/spi_frame_tx.sv
// ---------------------------------------------------------------------------
// spi_frame_tx
//
// SPI mode-0 master transmitter for one fixed-length frame. Generates sck,
// active-low cs and sdo from clk. Data leaves MSB first; sdo changes only on
// the clk edge where sck falls (or at cs assertion for the first bit), so it
// is stable for a full half-period around every rising sck edge.
//
// Ports:
//   clk      system clock, all logic on posedge
//   reset_n  synchronous, active-low reset; abandons any frame in flight
//   bus      spi_frame_tx_if.master: start/frame in; ready, busy, done,
//            sck, cs, sdo out (all outputs registered)
//
// Parameters:
//   FRAME_BITS  bits per frame (>=2)
//   CLK_DIV     clk cycles per sck half-period (>=1)
//   CS_SETUP    clk cycles cs low before the first sck rise (>=1)
//   CS_HOLD     clk cycles cs low after the last sck fall (>=1)
//   CS_GAP      extra cs-high cycles after done before ready (>=0)
//
// Optional build macro: SPI_TX_RESYNC_EN
//   When defined, the first frame after reset is preceded by two sck pulses
//   with cs high and sdo low. A receiver that clears its bit counter on an
//   sck rise with cs high is thereby flushed of any partial count left by a
//   mid-frame reset. Later frames skip this step.
// ---------------------------------------------------------------------------
module spi_frame_tx #(
  parameter int FRAME_BITS = 336,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  spi_frame_tx_if.master bus
);

  // Timer must hold the largest "last count" of any timed state.
  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam int BW    = $clog2(FRAME_BITS + 1);

  localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'((CS_GAP > 0) ? (CS_GAP - 1) : 0);
  localparam logic [BW-1:0] BITS_LAST  = BW'(FRAME_BITS - 1);
  localparam bit            HAS_GAP    = (CS_GAP > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_DONE,
    S_GAP
`ifdef SPI_TX_RESYNC_EN
    ,
    S_RESYNC
`endif
  } state_t;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  state_t                r_state;
  logic [TW-1:0]         r_tcnt;
  logic [BW-1:0]         r_bcnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_sck;
  logic                  r_cs;
  logic                  r_sdo;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_next;
  logic [TW-1:0]         w_tcnt_next;
  logic [BW-1:0]         w_bcnt_next;
  logic [FRAME_BITS-1:0] w_shift_next;
  logic                  w_sck_next;
  logic                  w_cs_next;
  logic                  w_sdo_next;
  logic                  w_ready_next;
  logic                  w_busy_next;
  logic                  w_done_next;

`ifdef SPI_TX_RESYNC_EN
  // r_resync_pend: set by reset, cleared once the flush pulses have gone out.
  // r_pulse: 0 while emitting the first flush pulse, 1 for the second.
  logic                  r_resync_pend;
  logic                  r_pulse;
  logic                  w_resync_pend_next;
  logic                  w_pulse_next;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_sck   <= 1'b0;
      r_cs    <= 1'b1;
      r_sdo   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SPI_TX_RESYNC_EN
      r_resync_pend <= 1'b1;
      r_pulse       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_tcnt  <= w_tcnt_next;
      r_bcnt  <= w_bcnt_next;
      r_shift <= w_shift_next;
      r_sck   <= w_sck_next;
      r_cs    <= w_cs_next;
      r_sdo   <= w_sdo_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
`ifdef SPI_TX_RESYNC_EN
      r_resync_pend <= w_resync_pend_next;
      r_pulse       <= w_pulse_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is a register, so the
  // values computed here are what the pins show one cycle later.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_tcnt_next  = r_tcnt + TW'(1);
    w_bcnt_next  = r_bcnt;
    w_shift_next = r_shift;
    w_sck_next   = r_sck;
    w_cs_next    = r_cs;
    w_sdo_next   = r_sdo;
    w_ready_next = 1'b0;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
`ifdef SPI_TX_RESYNC_EN
    w_resync_pend_next = r_resync_pend;
    w_pulse_next       = r_pulse;
`endif

    case (r_state)
      S_IDLE: begin
        w_tcnt_next  = '0;
        w_ready_next = 1'b1;
        if (bus.start && r_ready) begin
          // Accept: payload is captured here and never looked at again.
          w_shift_next = bus.frame;
          w_bcnt_next  = '0;
          w_busy_next  = 1'b1;
          w_ready_next = 1'b0;
          w_sck_next   = 1'b0;
`ifdef SPI_TX_RESYNC_EN
          if (r_resync_pend) begin
            // cs stays high and sdo low while the flush pulses run.
            w_state_next = S_RESYNC;
            w_sdo_next   = 1'b0;
            w_pulse_next = 1'b0;
          end else begin
            w_state_next = S_SETUP;
            w_cs_next    = 1'b0;
            w_sdo_next   = bus.frame[FRAME_BITS-1];
          end
`else
          w_state_next = S_SETUP;
          w_cs_next    = 1'b0;
          w_sdo_next   = bus.frame[FRAME_BITS-1];
`endif
        end
      end

`ifdef SPI_TX_RESYNC_EN
      S_RESYNC: begin
        // Two pulses of CLK_DIV low then CLK_DIV high, cs high throughout.
        if (r_tcnt == DIV_LAST) begin
          w_tcnt_next = '0;
          if (!r_sck) begin
            w_sck_next = 1'b1;
          end else begin
            w_sck_next = 1'b0;
            if (r_pulse) begin
              // Flush complete: fall straight into the normal frame start.
              w_pulse_next       = 1'b0;
              w_resync_pend_next = 1'b0;
              w_state_next       = S_SETUP;
              w_cs_next          = 1'b0;
              w_sdo_next         = r_shift[FRAME_BITS-1];
            end else begin
              w_pulse_next = 1'b1;
            end
          end
        end
      end
`endif

      S_SETUP: begin
        if (r_tcnt == SETUP_LAST) begin
          w_tcnt_next  = '0;
          w_state_next = S_LOW;
        end
      end

      S_LOW: begin
        if (r_tcnt == DIV_LAST) begin
          w_tcnt_next  = '0;
          w_sck_next   = 1'b1;
          w_state_next = S_HIGH;
        end
      end

      S_HIGH: begin
        if (r_tcnt == DIV_LAST) begin
          w_tcnt_next = '0;
          w_sck_next  = 1'b0;
          w_bcnt_next = r_bcnt + BW'(1);
          if (r_bcnt == BITS_LAST) begin
            w_state_next = S_HOLD;
            w_sdo_next   = 1'b0;
          end else begin
            // Next bit appears together with the sck fall. The register is
            // rotated rather than shifted so that the sent MSB wraps into the
            // bottom; it is never transmitted again.
            w_state_next = S_LOW;
            w_shift_next = {r_shift[FRAME_BITS-2:0], r_shift[FRAME_BITS-1]};
            w_sdo_next   = r_shift[FRAME_BITS-2];
          end
        end
      end

      S_HOLD: begin
        if (r_tcnt == HOLD_LAST) begin
          w_tcnt_next  = '0;
          w_state_next = S_DONE;
          w_cs_next    = 1'b1;
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
        end
      end

      S_DONE: begin
        w_tcnt_next = '0;
        if (HAS_GAP) begin
          w_state_next = S_GAP;
        end else begin
          w_state_next = S_IDLE;
          w_ready_next = 1'b1;
        end
      end

      S_GAP: begin
        if (r_tcnt == GAP_LAST) begin
          w_tcnt_next  = '0;
          w_state_next = S_IDLE;
          w_ready_next = 1'b1;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle link.
        w_state_next = S_IDLE;
        w_tcnt_next  = '0;
        w_sck_next   = 1'b0;
        w_cs_next    = 1'b1;
        w_sdo_next   = 1'b0;
        w_busy_next  = 1'b0;
        w_ready_next = 1'b1;
      end
    endcase
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sck   = r_sck;
  assign bus.cs    = r_cs;
  assign bus.sdo   = r_sdo;

endmodule

// File: tb/tb_spi_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_tx
//
// Three transmitters share one clock:
//   0: FRAME_BITS=8, other parameters default
//   1: all defaults (336-bit frame)
//   2: FRAME_BITS=8, CLK_DIV=1, CS_GAP=0
// A link monitor samples the pins on the falling clk edge and derives what a
// receiver would see (captured bits, cs-low length, gaps, sck period, done
// alignment). Expected values come from the frame rules directly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_frame_tx;
  localparam int W = 336;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_n;
  logic [N-1:0] st;
  logic [W-1:0] fr [N];

  int total = 0;
  int bad   = 0;

  spi_frame_tx_if #(.FRAME_BITS(8))   if_a ();
  spi_frame_tx_if #(.FRAME_BITS(336)) if_b ();
  spi_frame_tx_if #(.FRAME_BITS(8))   if_c ();

  assign if_a.start = st[0];
  assign if_a.frame = fr[0][7:0];
  assign if_b.start = st[1];
  assign if_b.frame = fr[1];
  assign if_c.start = st[2];
  assign if_c.frame = fr[2][7:0];

  spi_frame_tx #(.FRAME_BITS(8)) dut_a (.clk(clk), .reset_n(rst_n[0]), .bus(if_a));
  spi_frame_tx #(.FRAME_BITS(336)) dut_b (.clk(clk), .reset_n(rst_n[1]), .bus(if_b));
  spi_frame_tx #(.FRAME_BITS(8), .CLK_DIV(1), .CS_GAP(0)) dut_c (.clk(clk), .reset_n(rst_n[2]), .bus(if_c));

  logic [N-1:0] m_sck, m_cs, m_sdo, m_done, m_ready, m_busy;
  assign m_sck   = {if_c.sck,   if_b.sck,   if_a.sck};
  assign m_cs    = {if_c.cs,    if_b.cs,    if_a.cs};
  assign m_sdo   = {if_c.sdo,   if_b.sdo,   if_a.sdo};
  assign m_done  = {if_c.done,  if_b.done,  if_a.done};
  assign m_ready = {if_c.ready, if_b.ready, if_a.ready};
  assign m_busy  = {if_c.busy,  if_b.busy,  if_a.busy};

  int fb [N] = '{8, 336, 8};

  // Monitor state
  logic [N-1:0] p_sck = '0, p_cs = '1, p_sdo = '0, p_done = '0, d2r_arm = '0;
  int rises_cur [N]  = '{default:0};
  int rises_last [N] = '{default:0};
  int hi_rises [N]   = '{default:0};
  int cs_cur [N]     = '{default:0};
  int cs_last [N]    = '{default:0};
  int cs_falls [N]   = '{default:0};
  int high_run [N]   = '{default:0};
  int gap_last [N]   = '{default:0};
  int done_cnt [N]   = '{default:0};
  int done_rise [N]  = '{default:0};
  int done_long [N]  = '{default:0};
  int d2r_cur [N]    = '{default:0};
  int d2r_last [N]   = '{default:0};
  int since_rise [N] = '{default:0};
  int per_min [N]    = '{default:0};
  int per_max [N]    = '{default:0};
  int stable_err [N] = '{default:0};
  int sdo0 [N]       = '{default:0};
  int rx_cnt [N]     = '{default:0};
  int rx_valid [N]   = '{default:0};
  logic [W-1:0] cap [N], cap_last [N], rx_data [N], rx_last [N];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      since_rise[i]++;
      if (p_cs[i] && !m_cs[i]) begin
        cs_falls[i]++;
        gap_last[i]  = high_run[i];
        cs_cur[i]    = 1;
        cap[i]       = '0;
        rises_cur[i] = 0;
        sdo0[i]      = 0;
        per_min[i]   = 100000;
        per_max[i]   = 0;
      end else if (!m_cs[i]) begin
        cs_cur[i]++;
      end
      if (m_sck[i] && !p_sck[i]) begin
        if (!m_cs[i]) begin
          cap[i] = {cap[i][W-2:0], m_sdo[i]};
          rises_cur[i]++;
          if (m_sdo[i] !== p_sdo[i]) stable_err[i]++;
          if (rises_cur[i] > 1) begin
            if (since_rise[i] < per_min[i]) per_min[i] = since_rise[i];
            if (since_rise[i] > per_max[i]) per_max[i] = since_rise[i];
          end
          // Receiver: counts bits on rises with cs low, clears on rises with cs high.
          rx_data[i] = {rx_data[i][W-2:0], m_sdo[i]};
          rx_cnt[i]++;
          if (rx_cnt[i] == fb[i]) begin
            rx_valid[i]++;
            rx_last[i] = rx_data[i];
            rx_cnt[i]  = 0;
          end
        end else begin
          hi_rises[i]++;
          rx_cnt[i] = 0;
        end
        since_rise[i] = 0;
      end
      if (!m_cs[i] && rises_cur[i] < fb[i] && !m_sdo[i]) sdo0[i]++;
      if (!p_cs[i] && m_cs[i]) begin
        cs_last[i]    = cs_cur[i];
        cap_last[i]   = cap[i];
        rises_last[i] = rises_cur[i];
        high_run[i]   = 1;
        if (m_done[i]) done_rise[i]++;
      end else if (m_cs[i]) begin
        high_run[i]++;
      end
      if (m_done[i]) begin
        done_cnt[i]++;
        if (p_done[i]) done_long[i]++;
        d2r_arm[i] = 1'b1;
        d2r_cur[i] = 0;
      end else if (d2r_arm[i]) begin
        d2r_cur[i]++;
        if (m_ready[i]) begin
          d2r_last[i] = d2r_cur[i];
          d2r_arm[i]  = 1'b0;
        end
      end
      p_sck[i]  = m_sck[i];
      p_cs[i]   = m_cs[i];
      p_sdo[i]  = m_sdo[i];
      p_done[i] = m_done[i];
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (!m_ready[idx] && n < 5000) begin
      tick(1);
      n++;
    end
    chk($sformatf("ready%0d", idx), W'(m_ready[idx]), W'(1));
  endtask

  task automatic wait_done(input int idx, input int target, input string tag);
    int n = 0;
    while (done_cnt[idx] < target && n < 5000) begin
      tick(1);
      n++;
    end
    chk(tag, W'(done_cnt[idx]), W'(target));
  endtask

  task automatic wait_falls(input int idx, input int target, input string tag);
    int n = 0;
    while (cs_falls[idx] < target && n < 5000) begin
      tick(1);
      n++;
    end
    chk(tag, W'(cs_falls[idx]), W'(target));
  endtask

  // One-cycle start pulse, then wait for the frame's done pulse.
  task automatic send(input int idx, input logic [W-1:0] f);
    int d0;
    wait_ready(idx);
    d0 = done_cnt[idx];
    fr[idx] = f;
    st[idx] = 1'b1;
    tick(1);
    st[idx] = 1'b0;
    wait_done(idx, d0 + 1, $sformatf("done%0d", idx));
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] f;
    for (int j = 0; j < W; j += 16) f[j +: 16] = 16'($urandom);
    return f;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] f, g, fbytes;
    logic [7:0]   b2b [3];
    int base_f, base_d, rv0;

    rst_n = '0;
    st    = '0;
    for (int i = 0; i < N; i++) fr[i] = '0;
    tick(3);

    // Reset values, checked while reset is still applied.
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_cs%0d", i),    W'(m_cs[i]),    W'(1));
      chk($sformatf("rst_sck%0d", i),   W'(m_sck[i]),   W'(0));
      chk($sformatf("rst_sdo%0d", i),   W'(m_sdo[i]),   W'(0));
      chk($sformatf("rst_ready%0d", i), W'(m_ready[i]), W'(1));
      chk($sformatf("rst_busy%0d", i),  W'(m_busy[i]),  W'(0));
      chk($sformatf("rst_done%0d", i),  W'(m_done[i]),  W'(0));
    end
    rst_n = '1;
    tick(2);

    // 8-bit frame A5: MSB first, 8 rises, 2+32+2 cs-low cycles, done at cs rise.
    send(0, W'(8'hA5));
    chk("a5_data",  cap_last[0],         W'(8'hA5));
    chk("a5_rises", W'(rises_last[0]),   W'(8));
    chk("a5_cslow", W'(cs_last[0]),      W'(36));
    chk("a5_drise", W'(done_rise[0]),    W'(1));
    tick(6);
    chk("a5_d2r",   W'(d2r_last[0]),     W'(3));

    // Random 8-bit frames on both 8-bit instances.
    for (int k = 0; k < 4; k++) begin
      f = W'($urandom_range(0, 255));
      tick($urandom_range(0, 5));
      send(0, f);
      chk($sformatf("ra_data%0d", k),  cap_last[0],       f);
      chk($sformatf("ra_cslow%0d", k), W'(cs_last[0]),    W'(36));
      g = W'($urandom_range(0, 255));
      send(2, g);
      chk($sformatf("rc_data%0d", k),  cap_last[2],       g);
      chk($sformatf("rc_rises%0d", k), W'(rises_last[2]), W'(8));
      chk($sformatf("rc_cslow%0d", k), W'(cs_last[2]),    W'(2 + 16 + 2));
    end

    // CLK_DIV=1, CS_GAP=0, all ones: 2-cycle sck, sdo held at 1, ready right after done.
    send(2, W'(8'hFF));
    tick(2);
    chk("ff_data",  cap_last[2],      W'(8'hFF));
    chk("ff_pmin",  W'(per_min[2]),   W'(2));
    chk("ff_pmax",  W'(per_max[2]),   W'(2));
    chk("ff_sdo0",  W'(sdo0[2]),      W'(0));
    chk("ff_d2r",   W'(d2r_last[2]),  W'(1));

    // Full default frame with bytes 01..2A.
    for (int i = 0; i < 42; i++) fbytes[(41 - i) * 8 +: 8] = 8'(i + 1);
    send(1, fbytes);
    chk("b_data",   cap_last[1],      fbytes);
    chk("b_cslow",  W'(cs_last[1]),   W'(1348));
    chk("b_rises",  W'(rises_last[1]), W'(336));
    chk("b_rxval",  W'(rx_valid[1]),  W'(1));
    chk("b_rxdata", rx_last[1],       fbytes);

    // start pulses at SETUP, mid-HIGH and HOLD are ignored.
    wait_ready(0);
    base_f = cs_falls[0];
    base_d = done_cnt[0];
    f = W'($urandom_range(0, 255));
    fr[0] = f;
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      st[0] = (k == 1 || k == 5 || k == 35);
      fr[0] = W'($urandom_range(0, 255));
    end
    st[0] = 1'b0;
    wait_done(0, base_d + 1, "busy_done");
    tick(20);
    chk("busy_falls", W'(cs_falls[0]), W'(base_f + 1));
    chk("busy_dcnt",  W'(done_cnt[0]), W'(base_d + 1));
    chk("busy_data",  cap_last[0],     f);

    // Back-to-back with start held: 4-cycle cs-high gaps, mid-frame changes ignored.
    wait_ready(0);
    base_f = cs_falls[0];
    base_d = done_cnt[0];
    for (int k = 0; k < 3; k++) b2b[k] = 8'($urandom_range(0, 255));
    fr[0] = W'(b2b[0]);
    st[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_falls(0, base_f + k + 1, $sformatf("b2b_fall%0d", k));
      if (k > 0) chk($sformatf("b2b_gap%0d", k), W'(gap_last[0]), W'(4));
      if (k == 2) st[0] = 1'b0;
      tick(8);
      fr[0] = W'(~b2b[k]);
      tick(8);
      fr[0] = (k < 2) ? W'(b2b[k + 1]) : W'(~b2b[k]);
      wait_done(0, base_d + k + 1, $sformatf("b2b_done%0d", k));
      chk($sformatf("b2b_data%0d", k), cap_last[0], W'(b2b[k]));
    end
    tick(20);
    chk("b2b_falls", W'(cs_falls[0]), W'(base_f + 3));
    chk("b2b_dcnt",  W'(done_cnt[0]), W'(base_d + 3));

    // Reset at bit 100 of a 336-bit frame: link idles at once, no done pulse.
    wait_ready(1);
    base_d = done_cnt[1];
    fr[1] = rand_wide();
    st[1] = 1'b1;
    tick(1);
    st[1] = 1'b0;
    begin
      int n = 0;
      while (!(rises_cur[1] == 100 && !m_cs[1]) && n < 5000) begin
        tick(1);
        n++;
      end
      chk("mr_reach", W'(rises_cur[1]), W'(100));
    end
    rst_n[1] = 1'b0;
    tick(1);
    rst_n[1] = 1'b1;
    chk("mr_cs",    W'(m_cs[1]),    W'(1));
    chk("mr_sck",   W'(m_sck[1]),   W'(0));
    chk("mr_ready", W'(m_ready[1]), W'(1));
    chk("mr_done",  W'(m_done[1]),  W'(0));
    chk("mr_busy",  W'(m_busy[1]),  W'(0));
    tick(20);
    chk("mr_nodone", W'(done_cnt[1]), W'(base_d));
    rv0 = rx_valid[1];
    g = rand_wide();
    send(1, g);
    chk("mr_data",  cap_last[1],    g);
    chk("mr_cslow", W'(cs_last[1]), W'(1348));
`ifdef SPI_TX_RESYNC_EN
    chk("mr_rxval",  W'(rx_valid[1]), W'(rv0 + 1));
    chk("mr_rxdata", rx_last[1],      g);
`else
    chk("mr_rxmin",  W'(rx_valid[1] >= rv0), W'(1));
`endif

    // Link-wide properties over the whole run.
    for (int i = 0; i < N; i++) begin
      chk($sformatf("stable%0d", i),   W'(stable_err[i]), W'(0));
      chk($sformatf("donelong%0d", i), W'(done_long[i]),  W'(0));
      chk($sformatf("drise%0d", i),    W'(done_rise[i]),  W'(done_cnt[i]));
`ifdef SPI_TX_RESYNC_EN
      chk($sformatf("hirise%0d", i),   W'(hi_rises[i]),   W'((i == 1) ? 4 : 2));
`else
      chk($sformatf("hirise%0d", i),   W'(hi_rises[i]),   W'(0));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
